merlin_mem_arbiter: RTL
=======================

# merlin_mem_arbiter

Two-into-one request/response arbiter that lets the Merlin core's instruction port and data port share a single memory target, such as one SSRAM holding both code and data. It sits between the core and the memory. Each cycle it grants one requester, forwards that request to the memory port, and records the grant in an in-order tag FIFO. Each returning response is routed back to the port that issued it.

## Interface
Parameters:
- C_FIFO_DEPTH_LOG2, default 2: log2 of the maximum number of outstanding memory requests (4).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- resetn_i  in  1  reset; synchronous, active-low.
- ireqready_o  out  1  instruction request accepted.
- ireqvalid_i  in  1  instruction request valid.
- ireqaddr_i  in  32  instruction fetch address; always a 32-bit read.
- irspready_i  in  1  core can take an instruction response.
- irspvalid_o  out  1  instruction response valid.
- irsprerr_o  out  1  instruction read error.
- irspdata_o  out  32  instruction response data.
- dreqready_o  out  1  data request accepted.
- dreqvalid_i  in  1  data request valid.
- dreqwrite_i  in  1  data request is a write.
- dreqsize_i  in  2  access size: 0 byte, 1 half, 2 word.
- dreqaddr_i  in  32  data address.
- dreqdata_i  in  32  data write data.
- drspready_i  in  1  core can take a data response.
- drspvalid_o  out  1  data response valid.
- drsprerr_o  out  1  data read error.
- drspwerr_o  out  1  data write error.
- drspdata_o  out  32  data read data.
- mreqready_i  in  1  memory accepts a request.
- mreqvalid_o  out  1  memory request valid.
- mreqwrite_o  out  1  memory request is a write.
- mreqsize_o  out  2  memory access size.
- mreqaddr_o  out  32  memory address.
- mreqdata_o  out  32  memory write data.
- mrspready_o  out  1  arbiter can take a memory response.
- mrspvalid_i  in  1  memory response valid.
- mrsprerr_i  in  1  memory read error.
- mrspwerr_i  in  1  memory write error.
- mrspdata_i  in  32  memory response data.
- unexp_rsp_o  out  1  sticky flag: a response arrived while no request was outstanding.

## Operation
- A request transfers on `mreqvalid_o & mreqready_i`. The winning port's ready equals `mreqready_i & ~fifo_full`. The losing port's ready is 0.
- An instruction request is forwarded as a read with `mreqsize_o=2` and `mreqdata_o=0`.
- Grant lock: while `mreqvalid_o=1 & mreqready_i=0`, the granted port and a registered lock hold until the request transfers. A newly asserted valid on the other port cannot preempt it.
- Tag FIFO:
  - Depth `2**C_FIFO_DEPTH_LOG2`, 1 bit per entry (0 = I, 1 = D).
  - Pushed on each request transfer; popped on each response transfer (`mrspvalid_i & mrspready_o`).
  - When full, `mreqvalid_o=0` and both request readies are 0.
  - Full is evaluated before a same-cycle pop, so no push happens in the cycle that frees a slot.
  - Pointers wrap modulo depth. The count is C_FIFO_DEPTH_LOG2+1 bits.
- Response routing:
  - Head = I: `irspvalid_o = mrspvalid_i` and `mrspready_o = irspready_i`.
  - Head = D: the same relationship applies through the `drsp*` signals.
  - The unselected port's `rspvalid` is 0.
  - Data and error bits pass through combinationally to both ports.
  - `irsprerr_o = mrsprerr_i`. `mrspwerr_i` is routed only to `drspwerr_o`.
- Empty FIFO with `mrspvalid_i=1`:
  - `mrspready_o=1`; the response is dropped.
  - Neither `rspvalid` output asserts.
  - `unexp_rsp_o` sets and stays set until reset.

## Timing
- Request and response paths are combinational; no added latency.
- Grant, lock, RR pointer, FIFO and `unexp_rsp_o` are registered.
- While `resetn_i=0`, and in the first cycle after reset:
  - all readies and valids driven by the arbiter are 0, and `unexp_rsp_o=0`;
  - FIFO is empty, lock is clear, RR pointer = D.
- Reset mid-transaction discards all outstanding tags. The memory target must be reset in the same cycle.
- Back-to-back requests are allowed each cycle until the FIFO is full. A request and a response may transfer in the same cycle.

## Configuration
- MERLIN_ARB_RR_EN defined: round-robin arbitration.
  - When both ports are valid and no lock is held, the port not granted last wins.
  - The pointer updates on each transfer.
- MERLIN_ARB_RR_EN undefined: fixed priority. Data port wins when both are valid; the RR pointer is absent.

## Test plan
- Reset with `ireqvalid_i=1` held: all ready/valid outputs stay 0 until the first cycle after `resetn_i` rises; first transfer has `mreqaddr_o = ireqaddr_i`.
- Both valid every cycle, memory always ready, 1-cycle responses:
  - fixed priority gives D,D,D with instruction port starved;
  - with MERLIN_ARB_RR_EN, grants are D,I,D,I.
- `mreqready_i=0` for 3 cycles while I is granted, then D asserts valid: I request (addr 0x100) transfers first, then D.
- Issue 4 requests with no responses: 5th request sees ready=0 and `mreqvalid_o=0`. One response pops the FIFO; the next cycle accepts the request.
- Order I(0x0), D write (0x4), I(0x8): responses route to irsp, drsp (with `drspwerr_o` mirroring `mrspwerr_i=1`), irsp. `irspready_i=0` backpressures `mrspready_o` to 0.
- `mrspvalid_i=1` with FIFO empty: `mrspready_o=1`, no `rspvalid` output asserts, and `unexp_rsp_o` goes to 1 and stays until reset.

Source files
------------

// File: rtl/merlin_mem_arbiter.sv
// -----------------------------------------------------------------------------
// merlin_mem_arbiter
//
// Shares one memory target between the Merlin core's instruction and data
// ports. Each cycle one requester is granted and its request is forwarded
// combinationally to the memory port. Every accepted request records its
// origin in an in-order tag FIFO, so each response is steered back to the
// port that issued it.
//
// Ports
//   clk_i, resetn_i        clock, synchronous active-low reset
//   ireq*_i / ireqready_o  instruction request (always a 32-bit read)
//   irsp*_o / irspready_i  instruction response
//   dreq*_i / dreqready_o  data request (read or write, byte/half/word)
//   drsp*_o / drspready_i  data response
//   mreq*_o / mreqready_i  memory request
//   mrsp*_i / mrspready_o  memory response
//   unexp_rsp_o            sticky: a response arrived with nothing outstanding
//
// Configuration
//   MERLIN_ARB_RR_EN  defined   : round-robin between the two ports
//                     undefined : fixed priority, data port wins
// -----------------------------------------------------------------------------
module merlin_mem_arbiter #(
    parameter int C_FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [31:0] ireqaddr_i,
    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,
    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic        dreqwrite_i,
    input  logic [1:0]  dreqsize_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,
    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,
    input  logic        mreqready_i,
    output logic        mreqvalid_o,
    output logic        mreqwrite_o,
    output logic [1:0]  mreqsize_o,
    output logic [31:0] mreqaddr_o,
    output logic [31:0] mreqdata_o,
    output logic        mrspready_o,
    input  logic        mrspvalid_i,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i,
    output logic        unexp_rsp_o
);

    localparam int unsigned DEPTH = 2 ** C_FIFO_DEPTH_LOG2;
    localparam logic [C_FIFO_DEPTH_LOG2:0] FULL_CNT = {1'b1, {C_FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic                         en_q;      // low during reset and the cycle after
    logic                         lock_q, lock_d;
    logic                         grant_q;
    logic                         unexp_q, unexp_d;
    logic [DEPTH-1:0]             tag_q;
    logic [C_FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [C_FIFO_DEPTH_LOG2:0]   count_q, count_d;
`ifdef MERLIN_ARB_RR_EN
    logic                         rr_q;      // port that wins the next contested cycle
`endif

    logic sel, sel_valid, can_issue, push, pop, fifo_full, fifo_empty, head;

    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        head       = tag_q[rptr_q];

        // A stalled request keeps its grant so the memory sees a stable request.
        if (lock_q) begin
            sel = grant_q;
        end else if (ireqvalid_i && dreqvalid_i) begin
`ifdef MERLIN_ARB_RR_EN
            sel = rr_q;
`else
            sel = PORT_D;
`endif
        end else begin
            sel = dreqvalid_i ? PORT_D : PORT_I;
        end

        sel_valid   = (sel == PORT_D) ? dreqvalid_i : ireqvalid_i;
        can_issue   = en_q & ~fifo_full;
        mreqvalid_o = can_issue & sel_valid;
        ireqready_o = can_issue & mreqready_i & (sel == PORT_I);
        dreqready_o = can_issue & mreqready_i & (sel == PORT_D);

        if (sel == PORT_D) begin
            mreqwrite_o = dreqwrite_i;
            mreqsize_o  = dreqsize_i;
            mreqaddr_o  = dreqaddr_i;
            mreqdata_o  = dreqdata_i;
        end else begin
            mreqwrite_o = 1'b0;
            mreqsize_o  = 2'd2;
            mreqaddr_o  = ireqaddr_i;
            mreqdata_o  = '0;
        end

        push = mreqvalid_o & mreqready_i;

        // With nothing outstanding the response is accepted and dropped.
        mrspready_o = en_q & (fifo_empty | ((head == PORT_D) ? drspready_i : irspready_i));
        irspvalid_o = en_q & ~fifo_empty & (head == PORT_I) & mrspvalid_i;
        drspvalid_o = en_q & ~fifo_empty & (head == PORT_D) & mrspvalid_i;
        pop         = mrspvalid_i & mrspready_o & ~fifo_empty;

        irsprerr_o = mrsprerr_i;
        irspdata_o = mrspdata_i;
        drsprerr_o = mrsprerr_i;
        drspwerr_o = mrspwerr_i;
        drspdata_o = mrspdata_i;

        lock_d  = mreqvalid_o & ~mreqready_i;
        unexp_d = unexp_q | (en_q & fifo_empty & mrspvalid_i);
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        unexp_rsp_o = unexp_q;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            en_q    <= 1'b0;
            lock_q  <= 1'b0;
            grant_q <= PORT_D;
            unexp_q <= 1'b0;
            tag_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
`ifdef MERLIN_ARB_RR_EN
            rr_q    <= PORT_D;
`endif
        end else begin
            en_q    <= 1'b1;
            lock_q  <= lock_d;
            unexp_q <= unexp_d;
            count_q <= count_d;
            if (mreqvalid_o) grant_q <= sel;
            if (push) begin
                tag_q[wptr_q] <= sel;
                wptr_q        <= wptr_q + 1'b1;
`ifdef MERLIN_ARB_RR_EN
                rr_q          <= ~sel;
`endif
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule
